// File: rtl/fpalu_addsub_pipe.sv
// rtl/fpalu_addsub_pipe.sv - 3-stage pipelined floating-point add/subtract with status flags
// Optional macro FPADD_ROUND_RNE_EN selects round-to-nearest-even; default build truncates.
module fpalu_addsub_pipe #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 op_sub,
  input  logic [EXP_W+MAN_W:0] a_input,
  input  logic [EXP_W+MAN_W:0] b_input,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [EXP_W+MAN_W:0] sum,
  output logic                 ovf,
  output logic                 uflow,
  output logic                 invalid
);
  localparam int W       = 1 + EXP_W + MAN_W;
  localparam int SIG_W   = MAN_W + 4;
  localparam int ADD_W   = MAN_W + 5;
  localparam int XE_W    = EXP_W + 2;
  localparam int LZ_W    = $clog2(ADD_W);
  localparam int EXP_INF = (1 << EXP_W) - 1;
  localparam logic [EXP_W-1:0] EXP_MAX = '1;

  logic adv;
  logic s1_valid, s2_valid, s3_valid;

  // S1 combinational: unpack, classify, order by magnitude, align
  logic             a_s, b_s;
  logic [EXP_W-1:0] a_e, b_e;
  logic [MAN_W-1:0] a_f, b_f, a_fz, b_fz;
  logic             a_nan, b_nan, a_inf, b_inf, swap;
  logic             l_s;
  logic [EXP_W-1:0] l_e, sm_e, shift;
  logic [MAN_W-1:0] l_f, sm_f;
  logic [SIG_W-1:0] l_sig, sm_sig, sm_shifted;
  logic             sticky;
  logic             c1_spec, c1_inv;
  logic [W-1:0]     c1_spec_val;

  // pipeline registers
  logic             s1_sign, s1_sub, s1_spec, s1_inv;
  logic [EXP_W-1:0] s1_exp;
  logic [SIG_W-1:0] s1_sig_l, s1_sig_s;
  logic [W-1:0]     s1_spec_val;
  logic             s2_sign, s2_spec, s2_inv;
  logic [EXP_W-1:0] s2_exp;
  logic [ADD_W-1:0] s2_sum;
  logic [W-1:0]     s2_spec_val;

  logic [ADD_W-1:0] c2_sum;

  logic [LZ_W-1:0]         lzc;
  logic [ADD_W-2:0]        norm;
  logic signed [XE_W-1:0]  n_exp, r_exp;
  logic [MAN_W+1:0]        rnd;
  logic [MAN_W-1:0]        frac_out;
  logic                    inc;
  logic [W-1:0]            c3_sum;
  logic                    c3_ovf, c3_uflow, c3_inv;

  assign adv       = !s3_valid || out_ready;
  assign in_ready  = adv;
  assign out_valid = s3_valid;

  always_comb begin
    a_s  = a_input[W-1];
    a_e  = a_input[W-2:MAN_W];
    a_f  = a_input[MAN_W-1:0];
    b_s  = b_input[W-1] ^ op_sub;
    b_e  = b_input[W-2:MAN_W];
    b_f  = b_input[MAN_W-1:0];
    a_nan = (a_e == EXP_MAX) && (a_f != '0);
    b_nan = (b_e == EXP_MAX) && (b_f != '0);
    a_inf = (a_e == EXP_MAX) && (a_f == '0);
    b_inf = (b_e == EXP_MAX) && (b_f == '0);
    // denormals are treated as zero
    a_fz = (a_e == '0) ? '0 : a_f;
    b_fz = (b_e == '0) ? '0 : b_f;
    swap = {b_e, b_fz} > {a_e, a_fz};
    l_s  = swap ? b_s  : a_s;
    l_e  = swap ? b_e  : a_e;
    l_f  = swap ? b_fz : a_fz;
    sm_e = swap ? a_e  : b_e;
    sm_f = swap ? a_fz : b_fz;
    l_sig  = {(l_e != '0), l_f, 3'b000};
    sm_sig = {(sm_e != '0), sm_f, 3'b000};
    shift  = l_e - sm_e;
    sticky = 1'b0;
    if (32'(shift) >= MAN_W + 3) begin
      sm_shifted = {{(SIG_W-1){1'b0}}, |sm_sig};
    end else begin
      for (int i = 0; i < SIG_W; i++)
        if (i < int'(shift)) sticky = sticky | sm_sig[i];
      sm_shifted = (sm_sig >> shift) | {{(SIG_W-1){1'b0}}, sticky};
    end
    c1_spec = a_nan || b_nan || a_inf || b_inf;
    c1_inv  = a_nan || b_nan || (a_inf && b_inf && (a_s != b_s));
    if (c1_inv)
      c1_spec_val = {1'b0, EXP_MAX, 1'b1, {(MAN_W-1){1'b0}}};
    else if (a_inf)
      c1_spec_val = {a_s, EXP_MAX, {MAN_W{1'b0}}};
    else
      c1_spec_val = {b_s, EXP_MAX, {MAN_W{1'b0}}};
  end

  // |larger| >= |smaller| so the subtraction never goes negative
  always_comb begin
    if (s1_sub)
      c2_sum = {1'b0, s1_sig_l} - {1'b0, s1_sig_s};
    else
      c2_sum = {1'b0, s1_sig_l} + {1'b0, s1_sig_s};
  end

  always_comb begin
    lzc = '0;
    for (int i = 0; i < ADD_W - 1; i++)
      if (s2_sum[i]) lzc = LZ_W'(ADD_W - 2 - i);
    if (s2_sum[ADD_W-1]) begin
      norm  = {s2_sum[ADD_W-1:2], s2_sum[1] | s2_sum[0]};
      n_exp = XE_W'(s2_exp) + XE_W'(1);
    end else begin
      norm  = s2_sum[ADD_W-2:0] << lzc;
      n_exp = XE_W'(s2_exp) - XE_W'(lzc);
    end
`ifdef FPADD_ROUND_RNE_EN
    inc = norm[2] & (norm[1] | norm[0] | norm[3]);
`else
    inc = 1'b0;
`endif
    rnd      = {1'b0, norm[MAN_W+3:3]} + {{(MAN_W+1){1'b0}}, inc};
    r_exp    = rnd[MAN_W+1] ? n_exp + XE_W'(1) : n_exp;
    frac_out = rnd[MAN_W+1] ? '0 : rnd[MAN_W-1:0];
    c3_ovf   = 1'b0;
    c3_uflow = 1'b0;
    c3_inv   = 1'b0;
    if (s2_spec) begin
      c3_sum = s2_spec_val;
      c3_inv = s2_inv;
    end else if (s2_sum == '0) begin
      c3_sum = '0;
    end else if (int'(r_exp) >= EXP_INF) begin
      c3_sum = {s2_sign, EXP_MAX, {MAN_W{1'b0}}};
      c3_ovf = 1'b1;
    end else if (int'(r_exp) <= 0) begin
      c3_sum   = {s2_sign, {(W-1){1'b0}}};
      c3_uflow = 1'b1;
    end else begin
      c3_sum = {s2_sign, r_exp[EXP_W-1:0], frac_out};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
      s3_valid <= 1'b0;
    end else if (adv) begin
      s1_valid <= in_valid;
      s2_valid <= s1_valid;
      s3_valid <= s2_valid;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_sign     <= 1'b0;
      s1_sub      <= 1'b0;
      s1_spec     <= 1'b0;
      s1_inv      <= 1'b0;
      s1_exp      <= '0;
      s1_sig_l    <= '0;
      s1_sig_s    <= '0;
      s1_spec_val <= '0;
      s2_sign     <= 1'b0;
      s2_spec     <= 1'b0;
      s2_inv      <= 1'b0;
      s2_exp      <= '0;
      s2_sum      <= '0;
      s2_spec_val <= '0;
      sum         <= '0;
      ovf         <= 1'b0;
      uflow       <= 1'b0;
      invalid     <= 1'b0;
    end else if (adv) begin
      if (in_valid) begin
        s1_sign     <= l_s;
        s1_sub      <= (a_s != b_s);
        s1_spec     <= c1_spec;
        s1_inv      <= c1_inv;
        s1_exp      <= l_e;
        s1_sig_l    <= l_sig;
        s1_sig_s    <= sm_shifted;
        s1_spec_val <= c1_spec_val;
      end
      if (s1_valid) begin
        s2_sign     <= s1_sign;
        s2_spec     <= s1_spec;
        s2_inv      <= s1_inv;
        s2_exp      <= s1_exp;
        s2_sum      <= c2_sum;
        s2_spec_val <= s1_spec_val;
      end
      if (s2_valid) begin
        sum     <= c3_sum;
        ovf     <= c3_ovf;
        uflow   <= c3_uflow;
        invalid <= c3_inv;
      end
    end
  end
endmodule

// File: tb/tb_fpalu_addsub_pipe.sv
// tb/tb_fpalu_addsub_pipe.sv - self-checking bench for fpalu_addsub_pipe (binary32)
// Honours FPADD_ROUND_RNE_EN to pick the expected rounding mode.
module tb_fpalu_addsub_pipe;
  logic        clk, rst, in_valid, in_ready, op_sub, out_valid, out_ready;
  logic [31:0] a_input, b_input, sum;
  logic        ovf, uflow, invalid;

  int n_pass = 0, n_fail = 0, n_total = 0, n_out = 0;
  string phase = "reset";
  logic [34:0] exp_q[$];
  logic [34:0] cur_exp;

  localparam logic [34:0] FL_OVF = 35'h1_0000_0000;
  localparam logic [34:0] FL_UF  = 35'h2_0000_0000;
  localparam logic [34:0] FL_INV = 35'h4_0000_0000;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        op;
    logic [34:0] e;
  } vec_t;
  vec_t dv[13];

  fpalu_addsub_pipe dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op_sub(op_sub),
    .a_input(a_input), .b_input(b_input), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .ovf(ovf), .uflow(uflow), .invalid(invalid)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Exact-value reference: operands become wide integers in units of 2^-149,
  // the exact sum is rounded once to 24 significant bits.
  function automatic logic [34:0] model(input logic [31:0] a, input logic [31:0] b, input logic sub);
    logic sa, sb, sr, g, st;
    int ea, eb, p, e;
    logic [22:0] fa, fb;
    logic [299:0] ma, mb, mag, rest;
    logic [24:0] keep;
    sa = a[31]; ea = int'(a[30:23]); fa = a[22:0];
    sb = b[31] ^ sub; eb = int'(b[30:23]); fb = b[22:0];
    if ((ea == 255 && fa != 0) || (eb == 255 && fb != 0) || (ea == 255 && eb == 255 && sa != sb))
      return FL_INV | 35'h7FC00000;
    if (ea == 255) return {3'b000, sa, 8'hFF, 23'd0};
    if (eb == 255) return {3'b000, sb, 8'hFF, 23'd0};
    ma = (ea == 0) ? '0 : (300'({1'b1, fa}) << (ea - 1));
    mb = (eb == 0) ? '0 : (300'({1'b1, fb}) << (eb - 1));
    if (sa == sb) begin mag = ma + mb; sr = sa; end
    else if (ma >= mb) begin mag = ma - mb; sr = sa; end
    else begin mag = mb - ma; sr = sb; end
    if (mag == '0) return 35'd0;
    p = 0;
    for (int i = 0; i < 300; i++) if (mag[i]) p = i;
    e = p - 22;
    if (p >= 24) begin
      keep = 25'(mag >> (p - 23));
      g    = mag[p - 24];
      rest = mag & ((300'd1 << (p - 24)) - 300'd1);
      st   = (rest != '0);
    end else begin
      keep = 25'(mag << (23 - p));
      g = 1'b0;
      st = 1'b0;
    end
`ifdef FPADD_ROUND_RNE_EN
    if (g && (st || keep[0])) keep = keep + 25'd1;
`endif
    if (keep[24]) begin keep = keep >> 1; e = e + 1; end
    if (e >= 255) return {3'b001, sr, 8'hFF, 23'd0};
    if (e <= 0) return {3'b010, sr, 31'd0};
    return {3'b000, sr, e[7:0], keep[22:0]};
  endfunction

  function automatic logic [31:0] rand_fp(input logic [31:0] near);
    logic [31:0] r;
    r = $urandom;
    case ($urandom_range(0, 6))
      0, 1: return r;
      2: return {r[31], 8'($urandom_range(120, 134)), r[22:0]};
      3: return {r[31], near[30:23], near[22:4], r[3:0]};
      4: return {r[31], r[0] ? 8'($urandom_range(250, 254)) : 8'($urandom_range(1, 4)), r[22:0]};
      5: return {r[31], near[30:23] - 8'($urandom_range(20, 30)), r[22:0]};
      default: begin
        case (r[2:0])
          3'd0: return 32'h00000000;
          3'd1: return 32'h80000000;
          3'd2: return 32'h7F800000;
          3'd3: return 32'hFF800000;
          3'd4: return 32'h7FC00000;
          3'd5: return 32'h00000001;
          3'd6: return 32'h7F7FFFFF;
          default: return 32'h00800000;
        endcase
      end
    endcase
  endfunction

  task automatic chk(input string tag, input logic [34:0] obs, input logic [34:0] expv);
    n_total = n_total + 1;
    assert (obs === expv) n_pass = n_pass + 1;
    else begin
      n_fail = n_fail + 1;
      $error("FAIL %s/%s: observed %h expected %h", phase, tag, obs, expv);
    end
  endtask

  // One clock: settle inputs, score any output transfer, record any input transfer.
  task automatic cycle(output logic fired);
    logic [34:0] e;
    #1;
    fired = in_valid && in_ready;
    if (out_valid && out_ready) begin
      n_out = n_out + 1;
      n_total = n_total + 1;
      assert (exp_q.size() > 0) n_pass = n_pass + 1;
      else begin
        n_fail = n_fail + 1;
        $error("FAIL %s/spurious_output: observed %h expected none", phase, sum);
      end
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("result", {invalid, uflow, ovf, sum}, e);
      end
    end
    if (fired) exp_q.push_back(cur_exp);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic op, input logic [34:0] e);
    logic f;
    a_input = a; b_input = b; op_sub = op; cur_exp = e; in_valid = 1'b1;
    f = 1'b0;
    for (int k = 0; k < 20 && !f; k++) cycle(f);
    chk("accept", {34'd0, f}, 35'd1);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    logic f;
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 60 && exp_q.size() != 0; k++) cycle(f);
    chk("drained", 35'(exp_q.size()), 35'd0);
  endtask

  initial begin
    logic f;
    logic have_op;
    int sent, got0;
    logic [31:0] sa[6], sb[6];
    logic [34:0] se0;

    rst = 1'b1; in_valid = 1'b0; op_sub = 1'b0; out_ready = 1'b1;
    a_input = '0; b_input = '0; cur_exp = '0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_out_valid", {34'd0, out_valid}, 35'd0);
    chk("rst_result", {invalid, uflow, ovf, sum}, 35'd0);
    chk("rst_in_ready", {34'd0, in_ready}, 35'd1);
    @(negedge clk);
    rst = 1'b0;

    phase = "latency";
    a_input = 32'h3F800000; b_input = 32'h3F800000; op_sub = 1'b0; in_valid = 1'b1;
    cur_exp = 35'h040000000;
    cycle(f);
    in_valid = 1'b0;
    chk("lat_accept", {34'd0, f}, 35'd1);
    chk("lat_c1", {34'd0, out_valid}, 35'd0);
    cycle(f);
    chk("lat_c2", {34'd0, out_valid}, 35'd0);
    cycle(f);
    chk("lat_c3", {34'd0, out_valid}, 35'd1);
    drain();

    phase = "directed";
    dv[0]  = '{32'h3FC00000, 32'h40100000, 1'b0, 35'h040700000};
    dv[1]  = '{32'h3F800000, 32'h3F800000, 1'b1, 35'h000000000};
`ifdef FPADD_ROUND_RNE_EN
    dv[2]  = '{32'h3F800001, 32'h33800000, 1'b0, 35'h03F800002};
`else
    dv[2]  = '{32'h3F800001, 32'h33800000, 1'b0, 35'h03F800001};
`endif
    dv[3]  = '{32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, FL_OVF | 35'h07F800000};
    dv[4]  = '{32'h7F800000, 32'h7F800000, 1'b1, FL_INV | 35'h07FC00000};
    dv[5]  = '{32'h7FC00001, 32'h3F800000, 1'b0, FL_INV | 35'h07FC00000};
    dv[6]  = '{32'hFF800000, 32'h3F800000, 1'b0, 35'h0FF800000};
    dv[7]  = '{32'h7F800000, 32'h7F800000, 1'b0, 35'h07F800000};
    dv[8]  = '{32'h00000001, 32'h3F800000, 1'b0, 35'h03F800000};
    dv[9]  = '{32'h00800001, 32'h00800000, 1'b1, FL_UF | 35'h000000000};
    dv[10] = '{32'h00800000, 32'h00800001, 1'b1, FL_UF | 35'h080000000};
    dv[11] = '{32'h40000000, 32'h3F800000, 1'b1, 35'h03F800000};
    dv[12] = '{32'h3F800000, 32'h40000000, 1'b1, 35'h0BF800000};
    for (int i = 0; i < 13; i++) send(dv[i].a, dv[i].b, dv[i].op, dv[i].e);
    drain();

    phase = "stall";
    for (int i = 0; i < 6; i++) begin
      sa[i] = rand_fp(32'h3F800000);
      sb[i] = rand_fp(sa[i]);
    end
    se0 = model(sa[0], sb[0], 1'b0);
    sent = 0;
    got0 = n_out;
    for (int c = 0; c < 40; c++) begin
      out_ready = !(c >= 3 && c < 7);
      if (sent < 6) begin
        a_input = sa[sent]; b_input = sb[sent]; op_sub = 1'b0;
        cur_exp = model(sa[sent], sb[sent], 1'b0);
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      if (c == 4 || c == 6) begin
        #1;
        chk("in_ready_low", {34'd0, in_ready}, 35'd0);
        chk("held_valid", {34'd0, out_valid}, 35'd1);
        chk("held_result", {invalid, uflow, ovf, sum}, se0);
      end
      cycle(f);
      if (f) sent = sent + 1;
      if (sent == 6 && exp_q.size() == 0) break;
    end
    chk("sent", 35'(sent), 35'd6);
    chk("received", 35'(n_out - got0), 35'd6);
    drain();

    phase = "random";
    have_op = 1'b0;
    for (int i = 0; i < 250; i++) begin
      if (!have_op && $urandom_range(0, 3) != 0) begin
        a_input = rand_fp(32'h3F800000);
        b_input = rand_fp(a_input);
        op_sub  = 1'($urandom_range(0, 1));
        cur_exp = model(a_input, b_input, op_sub);
        have_op = 1'b1;
      end
      in_valid  = have_op;
      out_ready = ($urandom_range(0, 9) < 7);
      cycle(f);
      if (f) have_op = 1'b0;
    end
    drain();

    phase = "reset_flight";
    out_ready = 1'b1;
    a_input = 32'h3F800000; b_input = 32'h40000000; op_sub = 1'b0; in_valid = 1'b1;
    cur_exp = 35'h040400000;
    cycle(f);
    a_input = 32'h40400000; cur_exp = 35'h040A00000;
    cycle(f);
    in_valid = 1'b0;
    out_ready = 1'b0;
    cycle(f);
    cycle(f);
    chk("pre_valid", {34'd0, out_valid}, 35'd1);
    rst = 1'b1;
    #1;
    chk("rst_valid", {34'd0, out_valid}, 35'd0);
    chk("rst_sum", {invalid, uflow, ovf, sum}, 35'd0);
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 5; k++) cycle(f);
    got0 = n_out;
    send(32'h3FC00000, 32'h40100000, 1'b0, 35'h040700000);
    drain();
    chk("post_rst_count", 35'(n_out - got0), 35'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
